// File: rtl/ctrl_pkg.sv
// Shared definitions for the Rtypeinst multicycle controller: opcodes, ALU
// operation codes, FSM state encoding and the packed control word.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_PUSH  = 6'b111000;
    localparam logic [5:0] OP_POP   = 6'b111001;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_STACK   = 3'd5,
        ST_ILLEGAL = 3'd6,
        ST_HALT    = 3'd7
    } state_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem2reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
        logic [4:0] alu_op;
        logic       push;
        logic       pop;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = 15'd0;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_PUSH, OP_POP: is_legal_op = 1'b1;
            default:                                                  is_legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_stack_op(input logic [5:0] op);
        case (op)
            OP_PUSH, OP_POP: is_stack_op = 1'b1;
            default:         is_stack_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Saturating occupancy counter for the hardware stack with a sticky error
// flag raised on a push request while full or a pop request while empty.
module stack_depth_tracker #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               err
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};

    logic [DEPTH_W-1:0] depth_r;
    logic               err_r;

    // Occupancy update and sticky error capture; requests at the limits are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_r <= DEPTH_ZERO;
            err_r   <= 1'b0;
        end else begin
            if (inc && !full) begin
                depth_r <= depth_r + DEPTH_ONE;
            end else if (dec && !empty) begin
                depth_r <= depth_r - DEPTH_ONE;
            end else begin
                depth_r <= depth_r;
            end
            if ((inc && full) || (dec && empty)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign full  = (depth_r >= DEPTH_MAX);
    assign empty = (depth_r == DEPTH_ZERO);
    assign depth = depth_r;
    assign err   = err_r;

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle control unit for the Rtypeinst datapath. Define CTRL_ILLEGAL_TRAP_EN
// to park the FSM in HALT after an undefined opcode instead of resuming fetch.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               Mem2Reg,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               PCSrc,
    output logic [4:0]         ALUOp,
    output logic               push,
    output logic               pop,
    output logic               instr_done,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_err,
    output logic               illegal
);

    state_e     state_r;
    state_e     next_state_s;
    logic [5:0] op_q_r;
    logic [5:0] funct_q_r;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_next_s;
    logic       illegal_r;
    logic       inc_s;
    logic       dec_s;
    logic       full_s;
    logic       empty_s;
    logic       beq_take_s;
    logic       unused_s;

    // Control word for a given state; full/empty are sampled before the stack moves.
    function automatic ctrl_t ctrl_decode(input state_e     st,
                                          input logic [5:0] opc,
                                          input logic [4:0] fn,
                                          input logic       full,
                                          input logic       empty);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_EXEC: begin
                case (opc)
                    OP_RTYPE: begin
                        c.reg_dst = 1'b1;
                        c.alu_op  = fn;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        c.alu_src = 1'b1;
                        c.alu_op  = ALU_ADD;
                    end
                    OP_BEQ: begin
                        c.alu_op     = ALU_SUB;
                        c.instr_done = 1'b1;
                    end
                    default: c = CTRL_IDLE;
                endcase
            end
            ST_MEM: begin
                case (opc)
                    OP_LW: begin
                        c.mem_read = 1'b1;
                        c.alu_src  = 1'b1;
                    end
                    OP_SW: begin
                        c.mem_write  = 1'b1;
                        c.alu_src    = 1'b1;
                        c.instr_done = 1'b1;
                    end
                    default: c = CTRL_IDLE;
                endcase
            end
            ST_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
                c.reg_dst    = (opc == OP_RTYPE);
                c.mem2reg    = (opc == OP_LW) || (opc == OP_POP);
            end
            ST_STACK: begin
                case (opc)
                    OP_PUSH: begin
                        c.push       = !full;
                        c.pc_src     = !full;
                        c.instr_done = 1'b1;
                    end
                    OP_POP: begin
                        // A successful pop finishes in WB, a failed one ends here.
                        c.pop        = !empty;
                        c.instr_done = empty;
                    end
                    default: c = CTRL_IDLE;
                endcase
            end
            ST_ILLEGAL: c.instr_done = 1'b1;
            default:    c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // Next-state decode.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (!is_legal_op(op_q_r)) begin
                    next_state_s = ST_ILLEGAL;
                end else if (is_stack_op(op_q_r)) begin
                    next_state_s = ST_STACK;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((op_q_r == OP_RTYPE) || (op_q_r == OP_ADDI)) begin
                    next_state_s = ST_WB;
                end else if ((op_q_r == OP_LW) || (op_q_r == OP_SW)) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (op_q_r == OP_LW) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB: next_state_s = ST_FETCH;
            ST_STACK: begin
                if (ctrl_r.pop) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_ILLEGAL: next_state_s = ST_HALT;
            ST_HALT:    next_state_s = ST_HALT;
`else
            ST_ILLEGAL: next_state_s = ST_FETCH;
            ST_HALT:    next_state_s = ST_FETCH;
`endif
            default: next_state_s = ST_FETCH;
        endcase
    end

    // Stack requests are issued on the edge that enters STACK so depth and
    // strobes line up within the STACK cycle.
    always_comb begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        if (next_state_s == ST_STACK) begin
            inc_s = (op_q_r == OP_PUSH);
            dec_s = (op_q_r == OP_POP);
        end else begin
            inc_s = 1'b0;
            dec_s = 1'b0;
        end
    end

    // Registered control word for the state being entered.
    always_comb begin
        ctrl_next_s = ctrl_decode(next_state_s, op_q_r, funct_q_r[4:0], full_s, empty_s);
    end

    // FSM state, instruction capture, registered controls and sticky illegal flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            op_q_r    <= 6'd0;
            funct_q_r <= 6'd0;
            ctrl_r    <= CTRL_IDLE;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_FETCH) begin
                op_q_r    <= op;
                funct_q_r <= funct;
            end else begin
                op_q_r    <= op_q_r;
                funct_q_r <= funct_q_r;
            end
            ctrl_r    <= ctrl_next_s;
            illegal_r <= illegal_r | (next_state_s == ST_ILLEGAL);
        end
    end

    stack_depth_tracker #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_s),
        .dec   (dec_s),
        .depth (depth),
        .full  (full_s),
        .empty (empty_s),
        .err   (stack_err)
    );

    // Branch resolution needs the live zero flag, so this term is not registered.
    assign beq_take_s = (state_r == ST_EXEC) && (op_q_r == OP_BEQ) && zero;

    assign RegDst     = ctrl_r.reg_dst;
    assign ALUSrc     = ctrl_r.alu_src;
    assign Mem2Reg    = ctrl_r.mem2reg;
    assign MemRead    = ctrl_r.mem_read;
    assign MemWrite   = ctrl_r.mem_write;
    assign RegWrite   = ctrl_r.reg_write;
    assign PCSrc      = ctrl_r.pc_src | beq_take_s;
    assign ALUOp      = ctrl_r.alu_op;
    assign push       = ctrl_r.push;
    assign pop        = ctrl_r.pop;
    assign instr_done = ctrl_r.instr_done;
    assign illegal    = illegal_r;
    assign unused_s   = funct_q_r[5];

endmodule

// File: tb/tb_ctrl_fsm.sv
// Table-driven, scoreboarded bench for ctrl_fsm: per-cycle expected control
// words are built from an instruction-level model and compared every cycle.
module tb_ctrl_fsm;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_PUSH  = 6'b111000;
    localparam logic [5:0] T_POP   = 6'b111001;
    localparam logic [5:0] T_BAD   = 6'b111111;

    // Control word layout: {RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc,ALUOp,push,pop,instr_done}
    localparam logic [14:0] C_REGDST = 15'h4000;
    localparam logic [14:0] C_ALUSRC = 15'h2000;
    localparam logic [14:0] C_M2R    = 15'h1000;
    localparam logic [14:0] C_MRD    = 15'h0800;
    localparam logic [14:0] C_MWR    = 15'h0400;
    localparam logic [14:0] C_RWR    = 15'h0200;
    localparam logic [14:0] C_PCSRC  = 15'h0100;
    localparam logic [14:0] C_PUSH   = 15'h0004;
    localparam logic [14:0] C_POP    = 15'h0002;
    localparam logic [14:0] C_DONE   = 15'h0001;
    localparam logic [14:0] C_NONE   = 15'h0000;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [14:0] ctl;
        logic [4:0]  dep;
        logic        serr;
        logic        ill;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc;
    logic [4:0] ALUOp;
    logic       push, pop, instr_done;
    logic [4:0] depth;
    logic       stack_err, illegal;

    vec_t       vecs[$];
    vec_t       sb[$];
    int         n_vec;
    int         n_bad;
    logic [4:0] m_depth;
    logic       m_serr;
    logic       m_ill;

    ctrl_fsm #(.STACK_DEPTH(16), .DEPTH_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .Mem2Reg    (Mem2Reg),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp),
        .push       (push),
        .pop        (pop),
        .instr_done (instr_done),
        .depth      (depth),
        .stack_err  (stack_err),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] alu(input logic [4:0] a);
        alu = {7'd0, a, 3'd0};
    endfunction

    function automatic logic [21:0] observed();
        observed = {RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc,
                    ALUOp, push, pop, instr_done, depth, stack_err, illegal};
    endfunction

    task automatic emit(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [14:0] c);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.ctl = c;
        v.dep = m_depth; v.serr = m_serr; v.ill = m_ill;
        vecs.push_back(v);
    endtask

    // Instruction-level model: one table entry per cycle of the instruction.
    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        emit(o, f, z, C_NONE);
        emit(o, f, z, C_NONE);
        case (o)
            T_RTYPE: begin
                emit(o, f, z, C_REGDST | alu(f[4:0]));
                emit(o, f, z, C_RWR | C_REGDST | C_DONE);
            end
            T_ADDI: begin
                emit(o, f, z, C_ALUSRC | alu(5'd0));
                emit(o, f, z, C_RWR | C_DONE);
            end
            T_LW: begin
                emit(o, f, z, C_ALUSRC | alu(5'd0));
                emit(o, f, z, C_MRD | C_ALUSRC);
                emit(o, f, z, C_RWR | C_M2R | C_DONE);
            end
            T_SW: begin
                emit(o, f, z, C_ALUSRC | alu(5'd0));
                emit(o, f, z, C_MWR | C_ALUSRC | C_DONE);
            end
            T_BEQ: emit(o, f, z, alu(5'd1) | C_DONE | (z ? C_PCSRC : C_NONE));
            T_PUSH: begin
                if (m_depth < 5'd16) begin
                    m_depth = m_depth + 5'd1;
                    emit(o, f, z, C_PUSH | C_PCSRC | C_DONE);
                end else begin
                    m_serr = 1'b1;
                    emit(o, f, z, C_DONE);
                end
            end
            T_POP: begin
                if (m_depth > 5'd0) begin
                    m_depth = m_depth - 5'd1;
                    emit(o, f, z, C_POP);
                    emit(o, f, z, C_RWR | C_M2R | C_DONE);
                end else begin
                    m_serr = 1'b1;
                    emit(o, f, z, C_DONE);
                end
            end
            default: begin
                m_ill = 1'b1;
                emit(o, f, z, C_DONE);
            end
        endcase
    endtask

    // Applies the table; expects to be called at a negedge in FETCH and returns at one.
    task automatic run_table(input string tag);
        vec_t e;
        int   idx;
        idx = 0;
        while (vecs.size() > 0) begin
            e = vecs.pop_front();
            op = e.op; funct = e.funct; zero = e.zero;
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            n_vec++;
            if (observed() !== {e.ctl, e.dep, e.serr, e.ill}) begin
                n_bad++;
                $display("FAIL %s[%0d]: got ctl=%h depth=%0d serr=%b ill=%b, expected ctl=%h depth=%0d serr=%b ill=%b",
                         tag, idx, observed() >> 7, depth, stack_err, illegal, e.ctl, e.dep, e.serr, e.ill);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        op = 6'd0; funct = 6'd0; zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {10'd0, observed()}, 32'd0);
        reset = 1'b1;
        m_depth = 5'd0; m_serr = 1'b0; m_ill = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
        m_depth = 5'd0; m_serr = 1'b0; m_ill = 1'b0;
        do_reset();

        // Main instruction mix, stack fill to the boundary and overflow.
        instr(T_RTYPE, 6'b000010, 1'b0);
        instr(T_ADDI, 6'b000000, 1'b1);
        instr(T_LW, 6'b000000, 1'b0);
        instr(T_SW, 6'b000000, 1'b0);
        instr(T_BEQ, 6'b000000, 1'b1);
        instr(T_BEQ, 6'b000000, 1'b0);
        instr(T_PUSH, 6'b000000, 1'b0);
        instr(T_POP, 6'b000000, 1'b0);
        for (int i = 0; i < 17; i++) instr(T_PUSH, 6'b000000, 1'b0);
        instr(T_POP, 6'b000000, 1'b0);
        instr(T_RTYPE, 6'b110101, 1'b0);
        run_table("main");

        // Reset asserted mid-LW while in MEM.
        op = T_LW; funct = 6'd0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("lw_mem_read", {31'd0, MemRead}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {10'd0, observed()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_depth = 5'd0; m_serr = 1'b0; m_ill = 1'b0;
        instr(T_RTYPE, 6'b000111, 1'b0);
        instr(T_POP, 6'b000000, 1'b0);
        instr(T_BAD, 6'b000000, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) emit(T_RTYPE, 6'b000000, 1'b1, C_NONE);
        run_table("trap");
        do_reset();
        instr(T_ADDI, 6'b000000, 1'b0);
        run_table("after_halt");
`else
        instr(T_ADDI, 6'b000000, 1'b0);
        run_table("after_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
